uart_cmd_ctrl: RTL and testbench

Command-frame controller that sits behind `uart_byte_rx`. It consumes received bytes (`rx_done`/`data_byte`), parses fixed 5-byte command frames, and either issues register writes or reprograms the receiver's `baud_set`. It closes the loop on the receiver configuration and is the single writer of `baud_set` in the design.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_timer.sv | 32 +++
 rtl/uart_cmd_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command-frame controller.
package uart_pkg;

   // Parser position within a 5-byte frame
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_CHK
   } state_e;

   localparam logic [7:0] HDR      = 8'hA5;
   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_BAUD = 8'h02;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CHK  = 2'd1;
   localparam logic [1:0] ERR_CMD  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   localparam logic [2:0] BAUD_MAX = 3'd4;

   // A command is executable if it is a register write, or a baud change
   // whose index names one of the supported rates.
   function automatic logic cmd_valid(input logic [7:0] cmd, input logic [7:0] data);
      return (cmd == CMD_WR) || ((cmd == CMD_BAUD) && (data <= {5'd0, BAUD_MAX}));
   endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for the command-frame parser.
module uart_frame_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   // The count lags elapsed cycles by one (it is 0 in the cycle after the
   // clearing byte), and expiry is flagged one cycle before the error must be
   // visible so the registered error lands exactly TIMEOUT_CYCLES after the
   // last byte.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // Count while a frame is open; any byte or an idle parser clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            cnt <= '0;
      else if (clr || !run)  cnt <= '0;
      else                   cnt <= cnt + ONE;
   end

   // A byte in the expiry cycle takes priority, so it masks the expiry
   assign expired = run && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses A5/CMD/ADDR/DATA/CHK frames from the byte receiver and issues
// register writes or baud-rate changes; single owner of baud_set.
module uart_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   output logic [2:0] baud_set,
   output logic       reg_wr_en,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   state_e     state_q, state_d;
   logic [7:0] cmd_q, addr_q, data_q, sum_q;
   logic       tmo;
   logic       frame_end, chk_ok, cmd_ok;

   logic       wr_en_d, ok_d, err_d;
   logic [1:0] code_d;
   logic [2:0] baud_d;
   logic [7:0] addr_d, wdata_d;

   uart_frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (rx_done),
      .run     (state_q != ST_IDLE),
      .expired (tmo)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state: advance on each byte, drop back to IDLE on timeout
   always_comb begin
      state_d = state_q;
      if (rx_done) begin
         case (state_q)
            ST_IDLE: state_d = (rx_data == HDR) ? ST_CMD : ST_IDLE;
            ST_CMD:  state_d = ST_ADDR;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: state_d = ST_CHK;
            ST_CHK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo) begin
         state_d = ST_IDLE;
      end
   end

   // Latch frame fields and accumulate the 8-bit wrapping checksum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         sum_q  <= '0;
      end else if (rx_done) begin
         case (state_q)
            ST_CMD: begin
               cmd_q <= rx_data;
               sum_q <= rx_data;
            end
            ST_ADDR: begin
               addr_q <= rx_data;
               sum_q  <= sum_q + rx_data;
            end
            ST_DATA: begin
               data_q <= rx_data;
               sum_q  <= sum_q + rx_data;
            end
            default: ;
         endcase
      end
   end

   assign frame_end = rx_done && (state_q == ST_CHK);
   assign chk_ok    = (sum_q == rx_data);
   assign cmd_ok    = cmd_valid(cmd_q, data_q);

   // Output decode: checksum is judged before command validity, and an
   // aborted frame leaves baud/address/data untouched
   always_comb begin
      wr_en_d = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      code_d  = err_code;
      baud_d  = baud_set;
      addr_d  = reg_addr;
      wdata_d = reg_wdata;
      if (frame_end) begin
         if (!chk_ok) begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
         end else if (!cmd_ok) begin
            err_d  = 1'b1;
            code_d = ERR_CMD;
         end else begin
            ok_d = 1'b1;
            if (cmd_q == CMD_WR) begin
               wr_en_d = 1'b1;
               addr_d  = addr_q;
               wdata_d = data_q;
            end else begin
               baud_d = data_q[2:0];
            end
         end
      end else if (tmo) begin
         err_d  = 1'b1;
         code_d = ERR_TMO;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_en <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
         baud_set  <= 3'd0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
      end else begin
         reg_wr_en <= wr_en_d;
         frame_ok  <= ok_d;
         frame_err <= err_d;
         err_code  <= code_d;
         baud_set  <= baud_d;
         reg_addr  <= addr_d;
         reg_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a byte-level frame model predicts
// events and their exact cycle; a negedge monitor pops and compares.
module tb_uart_cmd_ctrl;

   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [2:0] baud_set;
   logic       reg_wr_en;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_done   (rx_done),
      .rx_data   (rx_data),
      .baud_set  (baud_set),
      .reg_wr_en (reg_wr_en),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = register write, 1 = baud change, 2 = error (code)
   typedef struct {
      int kind;
      int addr;
      int data;
      int code;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   mdl_baud = 0, mdl_err = 0, mdl_addr = 0, mdl_wdata = 0;
   bit   finish_req = 0;
   bit   mon_done = 0;
   int   buf_q[$];
   int   last_t = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   exp_t e_cur;
   int   eb, ee, ea, ew;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_baud", int'(baud_set), 0);
         chk("rst_strobes", int'({reg_wr_en, frame_ok, frame_err}), 0);
         chk("rst_addr_wdata", int'({reg_addr, reg_wdata}), 0);
         chk("rst_err_code", int'(err_code), 0);
         mdl_baud = 0; mdl_err = 0; mdl_addr = 0; mdl_wdata = 0;
         q.delete();
      end else begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e_cur = q.pop_front();
            eb = (e_cur.kind == 1) ? e_cur.data : mdl_baud;
            ee = (e_cur.kind == 2) ? e_cur.code : mdl_err;
            ea = (e_cur.kind == 0) ? e_cur.addr : mdl_addr;
            ew = (e_cur.kind == 0) ? e_cur.data : mdl_wdata;
            chk("frame_ok", int'(frame_ok), int'(e_cur.kind != 2));
            chk("frame_err", int'(frame_err), int'(e_cur.kind == 2));
            chk("reg_wr_en", int'(reg_wr_en), int'(e_cur.kind == 0));
            chk("baud_set", int'(baud_set), eb);
            chk("err_code", int'(err_code), ee);
            chk("reg_addr", int'(reg_addr), ea);
            chk("reg_wdata", int'(reg_wdata), ew);
            mdl_baud = eb; mdl_err = ee; mdl_addr = ea; mdl_wdata = ew;
         end else begin
            chk("quiet_strobes", int'({reg_wr_en, frame_ok, frame_err}), 0);
            chk("hold_baud", int'(baud_set), mdl_baud);
            chk("hold_err_code", int'(err_code), mdl_err);
            chk("hold_addr_wdata", int'({reg_addr, reg_wdata}), (mdl_addr << 8) | mdl_wdata);
         end
         if (finish_req && !mon_done) begin
            chk("scoreboard_drained", q.size(), 0);
            mon_done = 1;
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic push_ev(input int kind, input int addr, input int data, input int code, input int t);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.cyc = t;
      q.push_back(e);
   endtask

   // An open frame with no byte for TMO cycles is reported TMO cycles after its last byte
   task automatic mdl_tmo(input int t);
      if (buf_q.size() > 0 && (t - last_t) >= TMO) begin
         push_ev(2, 0, 0, 3, last_t + TMO);
         buf_q.delete();
      end
   endtask

   task automatic mdl_byte(input int b, input int t);
      int s;
      mdl_tmo(t);
      if (buf_q.size() == 0) begin
         if (b == 'hA5) buf_q.push_back(b);
      end else begin
         buf_q.push_back(b);
         if (buf_q.size() == 5) begin
            s = (buf_q[1] + buf_q[2] + buf_q[3]) % 256;
            if (buf_q[4] != s)                      push_ev(2, 0, 0, 1, t + 1);
            else if (buf_q[1] == 1)                 push_ev(0, buf_q[2], buf_q[3], 0, t + 1);
            else if (buf_q[1] == 2 && buf_q[3] <= 4) push_ev(1, 0, buf_q[3], 0, t + 1);
            else                                    push_ev(2, 0, 0, 2, t + 1);
            buf_q.delete();
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic byte_now(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   // Send byte b `gap` cycles after the previous byte (clamped to now)
   task automatic send(input int b, input int gap);
      int t;
      t = last_t + gap;
      if (t < cyc) t = cyc;
      mdl_byte(b, t);
      wait_until(t);
      byte_now(8'(b));
      last_t = t;
   endtask

   task automatic tail(input int n);
      int t;
      t = last_t + n;
      mdl_tmo(t);
      wait_until(t);
   endtask

   task automatic frame(input int c, input int a, input int d, input int k);
      send('hA5, 1); send(c, 1); send(a, 1); send(d, 1); send(k, 1);
   endtask

   task automatic do_reset(input int n);
      rx_done = 1'b0;
      rst_n = 1'b0;
      buf_q.delete();
      repeat (n) @(posedge clk);
      #1 rst_n = 1'b1;
      last_t = cyc;
   endtask

   int r, c, a, d, k, g, nj;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      last_t = cyc;

      // Register write with leading junk
      send('h00, 2); send('hFF, 1);
      frame('h01, 'h10, 'h3C, 'h4D);
      tail(5);
      // Baud changes, bad argument, checksum error then immediate valid frame
      frame('h02, 'h00, 'h03, 'h05);
      frame('h02, 'h00, 'h04, 'h06);
      frame('h02, 'h00, 'h07, 'h09);
      frame('h01, 'h10, 'h3C, 'h4E);
      frame('h01, 'h10, 'h3C, 'h4D);
      tail(3);
      // Timeout after header + command
      send('hA5, 1); send('h01, 1);
      tail(150);
      // Byte in the expiry cycle wins
      send('hA5, 1); send('h01, 1); send('h10, TMO - 1); send('h3C, 1); send('h4D, 1);
      tail(3);
      // Reset mid-frame after baud=3
      frame('h02, 'h00, 'h03, 'h05);
      tail(3);
      send('hA5, 1); send('h01, 1); send('h10, 1);
      do_reset(3);
      send('h3C, 2); send('h4D, 1);
      tail(5);

      // Randomized frames
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 5);
         c = 1; a = $urandom_range(0, 255); d = $urandom_range(0, 255);
         case (r)
            0: c = 1;
            1: begin c = 2; d = $urandom_range(0, 4); end
            2: c = $urandom_range(1, 2);
            3: begin c = $urandom_range(3, 255); if ($urandom_range(0, 1) == 1) c = 0; end
            4: begin c = 2; d = $urandom_range(5, 255); end
            default: ;
         endcase
         k = (c + a + d) % 256;
         if (r == 2) k = (k + $urandom_range(1, 255)) % 256;
         if (r == 5) begin
            nj = $urandom_range(1, 3);
            for (int j = 0; j < nj; j++) send($urandom_range(0, 255), $urandom_range(1, 3));
         end else begin
            send('hA5, $urandom_range(1, 3));
            for (int j = 0; j < 4; j++) begin
               g = $urandom_range(1, 4);
               if ($urandom_range(0, 39) == 0) g = (($urandom_range(0, 1) == 1) ? TMO - 1 : TMO);
               if ($urandom_range(0, 79) == 0) g = TMO + 30;
               case (j)
                  0: send(c, g);
                  1: send(a, g);
                  2: send(d, g);
                  default: send(k, g);
               endcase
            end
         end
      end
      tail(TMO + 10);

      finish_req = 1;
      for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
      if (!mon_done) begin
         $display("FAIL monitor_drain: got not-done, expected done");
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      end else begin
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      end
      $finish;
   end

endmodule
